// File: rtl/usb_kbd_decoder.sv
// USB HID boot-keyboard decoder: diffs each accepted report against the last committed one
// and queues one {pressed, keycode} event per changed modifier bit or key in a show-ahead FIFO.
module usb_kbd_decoder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [63:0] usb_report_i,
  input  logic        usb_report_valid_i,
  output logic        event_valid_o,
  output logic [8:0]  event_o,
  input  logic        event_ready_i,
  output logic        overflow_o,
  output logic        busy_o
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_MOD, S_BREAK, S_MAKE, S_COMMIT} state_t;

  state_t          state_r, state_nxt;
  logic [2:0]      idx_r, idx_nxt;
  logic [63:0]     prev_r, cur_r, pend_r;
  logic            pend_v;
  logic            rollover, accept;
  logic [7:0]      cur_mod, prev_mod;
  logic [5:0][7:0] cur_s, prev_s, src_s, oth_s;
  logic [7:0]      probe;
  logic            hit, dup, push;
  logic [8:0]      push_data;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr_en;

  // ErrorRollOver reports carry no key state and are dropped before they reach the scanner.
  assign rollover = usb_report_i[63:16] == {6{8'h01}};
  assign accept   = usb_report_valid_i && !rollover;

  assign cur_mod  = cur_r[7:0];
  assign prev_mod = prev_r[7:0];
  assign cur_s    = cur_r[63:16];
  assign prev_s   = prev_r[63:16];

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r + 3'd1;
    case (state_r)
      S_IDLE: begin
        idx_nxt = '0;
        if (pend_v || accept) state_nxt = S_MOD;
      end
      S_MOD:    if (idx_r == 3'd7) begin state_nxt = S_BREAK; idx_nxt = '0; end
      S_BREAK:  if (idx_r == 3'd5) begin state_nxt = S_MAKE;  idx_nxt = '0; end
      S_MAKE:   if (idx_r == 3'd5) begin state_nxt = S_COMMIT; idx_nxt = '0; end
      S_COMMIT: begin state_nxt = S_IDLE; idx_nxt = '0; end
      default:  begin state_nxt = S_IDLE; idx_nxt = '0; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      prev_r  <= '0;
      cur_r   <= '0;
      pend_r  <= '0;
      pend_v  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      if (state_r == S_IDLE) begin
        if (pend_v) begin
          cur_r  <= pend_r;
          pend_v <= accept;
          if (accept) pend_r <= usb_report_i;
        end else if (accept) begin
          cur_r <= usb_report_i;
        end
      end else if (accept) begin
        pend_r <= usb_report_i;
        pend_v <= 1'b1;
      end
      if (state_r == S_COMMIT) prev_r <= cur_r;
    end
  end

  // BREAK probes prev against cur, MAKE probes cur against prev; dup suppresses repeated slots.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    hit       = 1'b0;
    dup       = 1'b0;
    src_s     = (state_r == S_MAKE) ? cur_s : prev_s;
    oth_s     = (state_r == S_MAKE) ? prev_s : cur_s;
    probe     = src_s[idx_r];
    for (int k = 0; k < 6; k++) begin
      if (oth_s[k] == probe) hit = 1'b1;
      if ((3'(k) < idx_r) && (src_s[k] == probe)) dup = 1'b1;
    end
    if (state_r == S_MOD) begin
      push      = cur_mod[idx_r] != prev_mod[idx_r];
      push_data = {cur_mod[idx_r], 8'hE0 + {5'd0, idx_r}};
    end else if ((state_r == S_BREAK) || (state_r == S_MAKE)) begin
      push      = (probe != 8'h00) && !hit && !dup;
      push_data = {state_r == S_MAKE, probe};
    end
  end

  assign full  = count == FULL_CNT;
  assign pop   = event_ready_i && (count != '0);
  assign wr_en = push && (!full || pop);

  // NOTE: the FIFO storage is reset too, so the show-ahead head reads as zero after reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  assign event_valid_o = count != '0;
  assign event_o       = mem[rd_ptr];
  assign busy_o        = state_r != S_IDLE;

endmodule

// File: tb/tb_usb_kbd_decoder.sv
// Scoreboard bench for usb_kbd_decoder: a set-based report-diff model queues expected events,
// a negedge monitor pops and compares every event the CPU side consumes.
module tb_usb_kbd_decoder;
  localparam int DEPTH = 16;

  typedef byte unsigned kq_t[$];

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [63:0] usb_report_i = '0;
  logic        usb_report_valid_i = 1'b0;
  logic        event_valid_o;
  logic [8:0]  event_o;
  logic        event_ready_i = 1'b0;
  logic        overflow_o;
  logic        busy_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rdy_mode = 1;   // 0 = hold low, 1 = always ready, 2 = mostly ready

  logic [8:0]  exp_q[$];
  logic [63:0] m_prev = '0;
  logic [63:0] m_pend = '0;
  bit          m_pend_v = 1'b0;
  int          scan_end = 0;   // first cycle at which the modelled scanner is idle again

  usb_kbd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset_i            (reset_i),
    .usb_report_i       (usb_report_i),
    .usb_report_valid_i (usb_report_valid_i),
    .event_valid_o      (event_valid_o),
    .event_o            (event_o),
    .event_ready_i      (event_ready_i),
    .overflow_o         (overflow_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, required completion", name);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] m, input logic [7:0] s0 = 0,
                                     input logic [7:0] s1 = 0, input logic [7:0] s2 = 0,
                                     input logic [7:0] s3 = 0, input logic [7:0] s4 = 0,
                                     input logic [7:0] s5 = 0);
    return {s5, s4, s3, s2, s1, s0, 8'h00, m};
  endfunction

  function automatic bit has(input kq_t q, input byte unsigned v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Distinct non-zero keys held in a report, in slot order of first appearance.
  function automatic kq_t keys_of(input logic [63:0] r);
    kq_t q;
    for (int j = 0; j < 6; j++) begin
      byte unsigned v = r[16 + 8*j +: 8];
      if (v != 0 && !has(q, v)) q.push_back(v);
    end
    return q;
  endfunction

  function automatic bit is_rollover(input logic [63:0] r);
    return r[63:16] == {6{8'h01}};
  endfunction

  task automatic model_scan(input logic [63:0] r);
    kq_t pk = keys_of(m_prev);
    kq_t ck = keys_of(r);
    for (int i = 0; i < 8; i++)
      if (r[i] != m_prev[i]) exp_q.push_back({r[i], 8'hE0 + 8'(i)});
    foreach (pk[j]) if (!has(ck, pk[j])) exp_q.push_back({1'b0, pk[j]});
    foreach (ck[j]) if (!has(pk, ck[j])) exp_q.push_back({1'b1, ck[j]});
    m_prev = r;
  endtask

  // A scan occupies 22 cycles from strobe to the idle cycle; a held report starts on that idle cycle.
  task automatic model_tick(input bit stb, input logic [63:0] r);
    if (m_pend_v && cyc >= scan_end) begin
      model_scan(m_pend);
      scan_end = cyc + 22;
      m_pend_v = 1'b0;
    end
    if (stb && !is_rollover(r)) begin
      if (cyc >= scan_end && !m_pend_v) begin
        model_scan(r);
        scan_end = cyc + 22;
      end else begin
        m_pend   = r;
        m_pend_v = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit stb, input logic [63:0] r);
    bit s;
    @(posedge clk);
    #1;
    s = stb && !(m_pend_v && cyc >= scan_end);
    usb_report_valid_i = s;
    usb_report_i       = r;
    case (rdy_mode)
      0:       event_ready_i = 1'b0;
      1:       event_ready_i = 1'b1;
      default: event_ready_i = $urandom_range(15) != 0;
    endcase
    if (!reset_i) model_tick(s, r);
  endtask

  task automatic send(input logic [63:0] r);
    cycle(1'b1, r);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || m_pend_v || cyc < scan_end) && n < 200) begin
      cycle(1'b0, '0);
      n++;
    end
    if (n >= 200) fail_now("wait_idle");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || event_valid_o) && n < 300) begin
      cycle(1'b0, '0);
      n++;
    end
    if (n >= 300) fail_now("wait_drain");
  endtask

  function automatic logic [63:0] rnd_report();
    logic [63:0] r;
    if ($urandom_range(7) == 0) return {{6{8'h01}}, 8'($urandom), 8'($urandom)};
    r[15:0] = 16'($urandom);
    for (int j = 0; j < 6; j++)
      r[16 + 8*j +: 8] = ($urandom_range(2) == 0) ? 8'h00 : 8'(4 + $urandom_range(8));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset_i && event_valid_o && event_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL event_extra: got 0x%0h, required no event", event_o);
      end else begin
        check("event", 32'(event_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int cnt, first;

    // Reset held for two cycles clears every output.
    reset_i = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    check("rst_event_valid", 32'(event_valid_o), 0);
    check("rst_event",       32'(event_o), 0);
    check("rst_overflow",    32'(overflow_o), 0);
    check("rst_busy",        32'(busy_o), 0);
    reset_i = 1'b0;

    // All-zero report: no events, fixed 21-cycle busy window.
    send(mk(8'h00));
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, '0);
      @(negedge clk);
      if (busy_o) cnt++;
    end
    check("busy_cycles", 32'(cnt), 21);
    check("zero_report_no_events", 32'(event_valid_o), 0);

    // Single key press appears at T+16, then its release.
    wait_drain();
    send(mk(8'h00, 8'h04));
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, '0);
      @(negedge clk);
      if (event_valid_o && first == 0) first = k;
    end
    check("first_event_latency", 32'(first), 16);
    send(mk(8'h00));
    wait_idle();
    wait_drain();

    // Modifier plus duplicated key, then release of both.
    send(mk(8'h02, 8'h05, 8'h05));
    wait_idle();
    send(mk(8'h00));
    wait_idle();
    wait_drain();

    // Rollover report is ignored and leaves the committed state untouched.
    send(mk(8'h00, 8'h04));
    wait_idle();
    send({{6{8'h01}}, 16'h0000});
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    check("rollover_no_scan", 32'(busy_o), 0);
    send(mk(8'h00));
    wait_idle();
    wait_drain();

    // Back-to-back A, B, C: B is overwritten, C starts at T+23.
    send(mk(8'h00, 8'h10));
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    send(mk(8'h00, 8'h20));
    cycle(1'b0, '0);
    send(mk(8'h00, 8'h30));
    for (int k = 6; k <= 23; k++) begin
      cycle(1'b0, '0);
      @(negedge clk);
      if (k == 22) check("b2b_idle_gap", 32'(busy_o), 0);
      if (k == 23) check("b2b_pending_start", 32'(busy_o), 1);
    end
    wait_idle();
    send(mk(8'h00));
    wait_idle();
    wait_drain();

    // Randomised reports with mostly-ready consumer.
    rdy_mode = 2;
    for (int n = 0; n < 800; n++)
      cycle($urandom_range(3) == 0, rnd_report());
    wait_idle();
    rdy_mode = 1;
    wait_drain();
    check("random_no_overflow", 32'(overflow_o), 0);

    // Overflow: 14 + 14 events into a 16-deep FIFO with no pops keeps the oldest 16.
    send(mk(8'h00));
    wait_idle();
    wait_drain();
    rdy_mode = 0;
    send(mk(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
    wait_idle();
    check("ovf_not_yet", 32'(overflow_o), 0);
    send(mk(8'h00));
    wait_idle();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    check("ovf_set", 32'(overflow_o), 1);
    check("ovf_fifo_valid", 32'(event_valid_o), 1);
    rdy_mode = 1;
    wait_drain();
    check("ovf_sticky", 32'(overflow_o), 1);
    check("ovf_drained", 32'(event_valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_kbd_decoder.md
# usb_kbd_decoder

Turns USB HID boot-protocol keyboard reports from the HID host into a stream of key press/release events that the CPU reads from a small FIFO. Each accepted report is compared against the previous one, and one event is emitted per changed modifier bit or keycode. It sits inside the SoC, between the report/valid pair delivered by the USB host and the CPU's peripheral bus. It is the consumer end of the report interface.

## Interface
- FIFO_DEPTH, 16: event FIFO entries; power of two, at least 2.
- clk  input  1  system clock; single clock domain. Report inputs are already synchronous to clk, since CDC is done upstream.
- reset_i  input  1  synchronous, active-high reset.
- usb_report_i  input  64  boot report: byte 0 = modifiers, byte 1 = reserved (ignored), bytes 2..7 = keycode slots 0..5.
- usb_report_valid_i  input  1  one-cycle strobe; usb_report_i is valid in that cycle.
- event_valid_o  output  1  FIFO not empty.
- event_o  output  9  head event {pressed, keycode[7:0]}; show-ahead.
- event_ready_i  input  1  pop; effective only when event_valid_o=1.
- overflow_o  output  1  sticky: an event was dropped; cleared only by reset_i.
- busy_o  output  1  scan FSM not in IDLE.

## Operation
- Registers:
  - prev_r: last committed report (modifiers + 6 slots).
  - cur_r: report being scanned.
  - pend_r / pend_v: one-deep pending report.
- Capture:
  - Strobe while IDLE and pend_v=0: load cur_r and enter MOD.
  - Strobe while busy: load pend_r and set pend_v. A later strobe overwrites it, so the newest report wins.
  - In IDLE with pend_v=1: move pend_r to cur_r, clear pend_v, enter MOD.
- Rollover filter: a report with every slot equal to 0x01 (ErrorRollOver) is discarded at capture. It produces no events, and prev_r is unchanged.
- FSM states: IDLE, MOD, BREAK, MAKE, COMMIT.
  - MOD, 8 cycles, index i=0..7: if cur.mod[i] != prev.mod[i], push {cur.mod[i], 8'hE0+i}.
  - BREAK, 6 cycles, slot j=0..5: push {0, prev.slot[j]} when all of these hold:
    - prev.slot[j] != 0;
    - the value is absent from all cur slots;
    - the value is not equal to any prev.slot[k] with k<j.
  - MAKE, 6 cycles: the same rule with cur and prev swapped; push {1, cur.slot[j]}.
  - COMMIT, 1 cycle: prev_r <= cur_r, then go to IDLE.
- Membership tests are combinational over the 6 slots; one index per cycle.
- Event order in the FIFO: modifier bits 0..7, then breaks in slot order, then makes in slot order.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits, wrapping naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
  - Push while full with no pop in the same cycle: the event is dropped and overflow_o is set.
  - Push and pop in the same cycle while full: both take effect and no overflow is flagged.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
- Reset:
  - prev_r, cur_r, pend_r and pend_v are cleared to 0; the FSM returns to IDLE; FIFO pointers and count go to 0.
  - Outputs: event_valid_o=0, event_o=0 (the memory head reads as 0 after reset), overflow_o=0, busy_o=0.
  - Reset mid-scan abandons the scan with no commit.

## Timing
- Strobe at cycle T (IDLE, no pending): MOD index 0 at T+1, BREAK at T+9, MAKE at T+15, COMMIT at T+21, IDLE at T+22.
- Fixed scan length of 21 cycles, regardless of how many events are produced.
- A pending report starts at the cycle after IDLE is reached, i.e. T+23.
- An event pushed at cycle k is visible on event_valid_o/event_o at k+1.
- A pop at cycle k advances the head at k+1; event_valid_o drops at k+1 if the FIFO becomes empty.
- busy_o is high from T+1 through T+21 inclusive.
- No combinational path from usb_report_valid_i to any output.

## Test plan
- Reset: hold reset_i 2 cycles -> all outputs 0. Strobe an all-zero report -> no events; busy_o high for exactly 21 cycles.
- Single key: from idle, report slot0=0x04 -> exactly one event 0x104, visible at T+16. Then an all-zero report -> event 0x004.
- Modifier plus keys: mod=0x02, slot0=0x05, slot1=0x05 -> events 0x1E1 then 0x105 only (duplicate suppressed). Then mod=0x00 with no keys -> 0x0E1, then 0x005.
- Rollover: from state {slot0=0x04}, strobe a report with all slots 0x01 -> no events. Then an all-zero report -> 0x004, proving prev_r was unchanged.
- Overflow: FIFO_DEPTH=16, event_ready_i=0. A report with mod=0xFF and 6 distinct keys gives 14 events. Then an all-zero report gives 14 more; only 2 fit -> overflow_o=1 and 16 events retained. Pop all 16 in order, and check overflow_o stays 1.
- Back-to-back: strobes A, B, C at T, T+3, T+5 -> A scanned, B discarded, C scanned starting at T+23. Events reflect the A-then-C diff only.
